sweep_sig_compactor: RTL and testbench
======================================

Name: sweep_sig_compactor

Overview:
- Self-test harness stage for the synthesised single-output benchmark functions (14 inputs x0..x13, one output y0).
- Sits directly around the logic block under test.
  - Upstream: it drives the input vector, sweeping a programmable window of the input space.
  - Downstream: it consumes y0 and compacts the response stream into a MISR signature and a ones-count.
- Lets optimised and unoptimised netlists be compared in hardware by signature.

Parameters:
- N_IN, 14, width of the driven input vector (x0..x13 map to x_out[0]..x_out[13]).
- SIG_W, 16, MISR width.
- SIG_POLY, 16'h1021, MISR feedback polynomial; bit i set means tap i is XORed in.
- SIG_SEED, 16'h0000, MISR value loaded at each start.
- DUT_LAT, 0, cycles from x_out change to valid y_in; legal range 0..3 (0 means a combinational DUT).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
- cfg_base  in  N_IN  first input vector of the sweep; sampled with start.
- cfg_count  in  N_IN  number of vectors; 0 means the full 2^N_IN; sampled with start.
- x_out  out  N_IN  registered input vector to the DUT.
- y_in  in  1  DUT output y0.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the signature is final.
- signature  out  SIG_W  MISR value; held stable outside busy.
- ones_count  out  N_IN+1  number of sampled y_in == 1 in the last sweep.

Behaviour:
- Reset (async assert, sync deassert handled by the driver):
  - state=IDLE; x_out=0, busy=0, done=0.
  - signature=SIG_SEED, ones_count=0.
  - Latency pipe cleared.
- FSM states: IDLE, DRIVE, DRAIN, DONE.
- IDLE:
  - Accept start: latch base and count (count 0 -> 2^N_IN, held in an N_IN+1-bit counter).
  - Load signature=SIG_SEED, ones_count=0.
  - Next cycle: x_out=cfg_base, busy=1, state=DRIVE.
- DRIVE:
  - One vector per cycle: x_out increments by 1 modulo 2^N_IN (0x3FFF wraps to 0x0000).
  - Each presented vector pushes a valid bit into a DUT_LAT-deep pipe.
  - After the last vector has been presented for one cycle, go to DRAIN.
  - If DUT_LAT=0, go straight to DONE.
- Sampling:
  - A valid bit emerging from the pipe samples y_in that cycle. With DUT_LAT=0, y_in is sampled in the same cycle x_out holds the vector.
  - Each sample updates signature = (sig<<1) XOR (sig[SIG_W-1] ? SIG_POLY : 0) XOR {0..0, y_in}.
  - Each sample with y_in=1 increments ones_count (saturation never needed: max 2^N_IN fits).
- DRAIN:
  - x_out holds the last vector.
  - Remains until the pipe is empty (DUT_LAT cycles), then goes to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 in that same cycle, then IDLE.
- Totals:
  - Samples per sweep = count exactly.
  - busy high for count+DUT_LAT cycles.
  - done asserted in the cycle after the final sample.
- start while busy or in DONE is ignored (no queueing).
- signature and ones_count are only modified by samples and by an accepted start.
- x_out keeps its last value after a sweep.
- Reset mid-sweep: immediate return to reset values; the partial signature is discarded and no done pulse is issued.
- No X propagation: y_in is ignored whenever no valid bit is emerging.

Test Plan:
- DUT_LAT=0, y_in tied 0, base=0x0000, count=4 -> x_out 0,1,2,3 on consecutive cycles; busy 4 cycles; done in cycle 5; signature=0x0000, ones_count=0.
- DUT_LAT=0, y_in tied 1, count=1 -> signature=0x0001, ones_count=1; count=2 -> signature=0x0003, ones_count=2.
- Wrap: base=0x3FFE, count=3 -> x_out sequence 0x3FFE, 0x3FFF, 0x0000; exactly 3 samples.
- DUT_LAT=2, registered stand-in DUT with y=x_out[0], base=0, count=4 -> samples 0,1,0,1.
  - signature=0x0005, ones_count=2; busy 6 cycles; x_out holds 0x0003 during DRAIN.
- Full sweep count=0, y_in tied 1 -> 16384 samples; ones_count=16384; done exactly once.
- rst_n low during DRIVE at index 100 -> all outputs at reset values asynchronously; no done.
  - A start pulse during busy in a separate run is ignored and the sweep length is unchanged.

Source files
------------

// File: rtl/sweep_sig_compactor.sv
// sweep_sig_compactor
//   Self-test stage wrapped around a 14-input, single-output logic block.
//   It sweeps a programmable window of the input space, one vector per cycle,
//   and folds the block's response into a MISR signature and a ones-count.
//   Comparing optimised and unoptimised netlists then reduces to comparing
//   signatures.
//
// Ports
//   clk         rising-edge clock for all state
//   rst_n       asynchronous active-low reset
//   start       one-cycle sweep request, honoured only in IDLE
//   cfg_base    first vector of the sweep (sampled with start)
//   cfg_count   number of vectors, 0 = full 2^N_IN (sampled with start)
//   x_out       registered input vector to the block under test
//   y_in        response of the block under test
//   busy        high while vectors are presented or responses are draining
//   done        one-cycle pulse once signature/ones_count are final
//   signature   MISR value, stable outside busy
//   ones_count  number of sampled responses equal to 1 in the last sweep
//
// FSM
//   state | meaning
//   IDLE  | waiting for start; outputs hold results of the last sweep
//   DRIVE | presenting one vector per cycle
//   DRAIN | last vector held while in-flight responses are sampled
//   DONE  | single-cycle completion pulse, then back to IDLE

module sweep_sig_compactor #(
  parameter int                N_IN     = 14,
  parameter int                SIG_W    = 16,
  parameter logic [SIG_W-1:0]  SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0]  SIG_SEED = 16'h0000,
  parameter int                DUT_LAT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [N_IN-1:0]   cfg_base,
  input  logic [N_IN-1:0]   cfg_count,
  output logic [N_IN-1:0]   x_out,
  input  logic              y_in,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic [N_IN:0]     ones_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [N_IN:0]   CNT_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN:0]   CNT_FULL = {1'b1, {N_IN{1'b0}}};
  localparam logic [N_IN-1:0] X_ONE    = N_IN'(1);

  logic [1:0]       state_q;
  logic [N_IN:0]    remaining_q;
  logic             accept;
  logic             drive_vld;
  logic             sample_vld;
  logic             drain_pending;
  logic [SIG_W-1:0] sig_next;

  assign accept    = (state_q == ST_IDLE) && start;
  assign drive_vld = (state_q == ST_DRIVE);
  assign busy      = (state_q == ST_DRIVE) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_DONE);

  // Valid-bit pipe that tracks which cycles carry a response to be sampled.
  // drain_pending says whether anything is still in flight behind the stage
  // that is emerging this cycle.
  generate
    if (DUT_LAT == 0) begin : g_nolat
      assign sample_vld    = drive_vld;
      assign drain_pending = 1'b0;
    end else begin : g_lat
      localparam logic [DUT_LAT-1:0] REST_MASK = {DUT_LAT{1'b1}} >> 1;
      logic [DUT_LAT-1:0] pipe_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pipe_q <= '0;
        end else begin
          pipe_q[0] <= drive_vld;
          for (int i = 1; i < DUT_LAT; i++) begin
            pipe_q[i] <= pipe_q[i-1];
          end
        end
      end

      assign sample_vld    = pipe_q[DUT_LAT-1];
      assign drain_pending = |(pipe_q & REST_MASK);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      x_out       <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            x_out       <= cfg_base;
            remaining_q <= (cfg_count == '0) ? CNT_FULL : {1'b0, cfg_count};
            state_q     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          // remaining_q counts vectors still to present, including this one;
          // on the last one x_out is left holding it.
          if (remaining_q == CNT_ONE) begin
            state_q <= (DUT_LAT == 0) ? ST_DONE : ST_DRAIN;
          end else begin
            x_out       <= x_out + X_ONE;
            remaining_q <= remaining_q - CNT_ONE;
          end
        end
        ST_DRAIN: begin
          if (!drain_pending) begin
            state_q <= ST_DONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sig_next = {signature[SIG_W-2:0], 1'b0}
             ^ (signature[SIG_W-1] ? SIG_POLY : '0)
             ^ {{(SIG_W-1){1'b0}}, y_in};
  end

  // y_in is only looked at when a valid bit emerges, so an undriven or
  // X-valued response outside the sampling window never reaches the MISR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature  <= SIG_SEED;
      ones_count <= '0;
    end else if (accept) begin
      signature  <= SIG_SEED;
      ones_count <= '0;
    end else if (sample_vld) begin
      signature  <= sig_next;
      ones_count <= ones_count + {{N_IN{1'b0}}, y_in};
    end
  end

endmodule

// File: tb/tb_sweep_sig_compactor.sv
module tb_sweep_sig_compactor;

  logic        clk;
  logic        rst_n;
  logic        start0, start2;
  logic [13:0] cfg_base, cfg_count;
  logic [13:0] x0, x2;
  logic        y0, y2;
  logic        busy0, busy2, done0, done2;
  logic [15:0] sig0, sig2;
  logic [14:0] ones0, ones2;

  // Truth table of the stand-in logic block under test.
  bit tt [16384];
  bit s1, s2;

  int n_tests = 0;
  int n_fail  = 0;

  sweep_sig_compactor #(.DUT_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .cfg_base(cfg_base),
    .cfg_count(cfg_count), .x_out(x0), .y_in(y0), .busy(busy0),
    .done(done0), .signature(sig0), .ones_count(ones0));

  sweep_sig_compactor #(.DUT_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .cfg_base(cfg_base),
    .cfg_count(cfg_count), .x_out(x2), .y_in(y2), .busy(busy2),
    .done(done2), .signature(sig2), .ones_count(ones2));

  // Combinational block for dut0, two-register block for dut2.
  assign y0 = tt[x0];
  always @(posedge clk) begin
    s1 <= tt[x2];
    s2 <= s1;
  end
  assign y2 = s2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: responses of vectors base, base+1, ... (mod 2^14) folded into
  // the MISR in presentation order, plus a plain count of ones.
  task automatic model(input logic [13:0] base, input int n,
                       output logic [15:0] s, output logic [14:0] o);
    logic [13:0] v;
    bit b;
    s = 16'h0000;
    o = '0;
    for (int i = 0; i < n; i++) begin
      v = base + 14'(i);
      b = tt[v];
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
      o = o + 15'(b);
    end
  endtask

  task automatic fill_tt(input int mode);
    for (int i = 0; i < 16384; i++) begin
      case (mode)
        0:       tt[i] = 1'b0;
        1:       tt[i] = 1'b1;
        2:       tt[i] = i[0];
        default: tt[i] = $urandom_range(0, 1) == 1;
      endcase
    end
  endtask

  task automatic run_sweep(input bit use2, input logic [13:0] base, input logic [13:0] cnt,
                           input int ghost_at, input bit ghost_done, input string tag);
    int n, lat, bcyc, dcnt, dcyc, xerr;
    logic [15:0] esig;
    logic [14:0] eones;
    logic [13:0] xo, last;
    logic b, d, gs;
    n    = (cnt == 14'd0) ? 16384 : int'(cnt);
    lat  = use2 ? 2 : 0;
    last = base + 14'(n - 1);
    model(base, n, esig, eones);
    bcyc = 0; dcnt = 0; dcyc = -1; xerr = 0;
    @(negedge clk);
    cfg_base  = base;
    cfg_count = cnt;
    if (use2) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start2 = 1'b0;
    for (int cyc = 0; cyc < n + lat + 4; cyc++) begin
      xo = use2 ? x2 : x0;
      b  = use2 ? busy2 : busy0;
      d  = use2 ? done2 : done0;
      if (b) begin
        if (bcyc < n) begin
          if (xo !== base + 14'(bcyc)) xerr++;
        end else if (xo !== last) begin
          xerr++;
        end
        bcyc++;
      end
      if (d) begin
        dcnt++;
        if (dcyc < 0) dcyc = cyc;
      end
      gs = (cyc == ghost_at) || (ghost_done && d);
      if (use2) start2 = gs; else start0 = gs;
      @(posedge clk); #1;
    end
    start0 = 1'b0; start2 = 1'b0;
    chk({tag, "_busy_len"}, bcyc, n + lat);
    chk({tag, "_done_cnt"}, dcnt, 1);
    chk({tag, "_done_cyc"}, dcyc, n + lat);
    chk({tag, "_xseq_err"}, xerr, 0);
    chk({tag, "_sig"},  use2 ? sig2 : sig0, esig);
    chk({tag, "_ones"}, use2 ? ones2 : ones0, eones);
    chk({tag, "_xhold"}, use2 ? x2 : x0, last);
  endtask

  initial begin
    int cyc, dn, bz;
    logic [13:0] rb, rc;
    rst_n = 1'b0;
    start0 = 1'b0; start2 = 1'b0;
    cfg_base = '0; cfg_count = '0;
    fill_tt(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x0", x0, 0);       chk("rst_x2", x2, 0);
    chk("rst_busy0", busy0, 0); chk("rst_busy2", busy2, 0);
    chk("rst_done0", done0, 0); chk("rst_done2", done2, 0);
    chk("rst_sig0", sig0, 0);   chk("rst_sig2", sig2, 0);
    chk("rst_ones0", ones0, 0); chk("rst_ones2", ones2, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // y tied 0, four vectors from 0
    fill_tt(0);
    run_sweep(1'b0, 14'h0000, 14'd4, -1, 1'b0, "t_zero4");
    chk("t_zero4_sig_const", sig0, 16'h0000);

    // y tied 1, count 1 then 2
    fill_tt(1);
    run_sweep(1'b0, 14'h0123, 14'd1, -1, 1'b0, "t_one1");
    chk("t_one1_sig_const", sig0, 16'h0001);
    chk("t_one1_ones_const", ones0, 1);
    run_sweep(1'b0, 14'h0000, 14'd2, -1, 1'b0, "t_one2");
    chk("t_one2_sig_const", sig0, 16'h0003);
    chk("t_one2_ones_const", ones0, 2);

    // wrap of the input vector
    fill_tt(3);
    run_sweep(1'b0, 14'h3FFE, 14'd3, -1, 1'b0, "t_wrap");
    run_sweep(1'b1, 14'h3FFE, 14'd3, -1, 1'b0, "t_wrap_l2");

    // latency-2 block with y = x[0]
    fill_tt(2);
    run_sweep(1'b1, 14'h0000, 14'd4, -1, 1'b0, "t_lat2");
    chk("t_lat2_sig_const", sig2, 16'h0005);
    chk("t_lat2_ones_const", ones2, 2);

    // randomized windows and responses on both latencies
    fill_tt(3);
    for (int k = 0; k < 6; k++) begin
      rb = 14'($urandom_range(0, 16383));
      rc = 14'($urandom_range(1, 300));
      run_sweep(k[0], rb, rc, -1, 1'b0, "t_rand");
    end

    // start pulses during busy and during DONE are ignored
    run_sweep(1'b0, 14'($urandom_range(0, 16383)), 14'd20, 5, 1'b1, "t_ghost0");
    run_sweep(1'b1, 14'($urandom_range(0, 16383)), 14'd20, 19, 1'b1, "t_ghost2");

    // full sweep with y tied 1
    fill_tt(1);
    run_sweep(1'b0, 14'h0000, 14'd0, -1, 1'b0, "t_full");
    chk("t_full_ones_const", ones0, 16384);

    // asynchronous reset in the middle of a sweep
    fill_tt(3);
    @(negedge clk);
    cfg_base = 14'h0000; cfg_count = 14'd1000; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 0;
    while (x0 !== 14'd100 && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_reach100", x0, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x0", x0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_sig", sig0, 0);
    chk("mid_rst_ones", ones0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dn = 0; bz = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done0) dn++;
      if (busy0) bz++;
    end
    chk("mid_no_done", dn, 0);
    chk("mid_no_busy", bz, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
